branch_checkpoint_table: RTL

- Parametrised, age-ordered store of branch recovery checkpoints.
- Each checkpoint holds a rename map snapshot, free-list head, active-list id, color bit and delay-slot flag.
- Checkpoints are allocated at rename and released in order once resolved. On a misprediction the table squashes the mispredicted checkpoint and all younger ones, then emits a registered one-cycle restore packet followed by a configurable allocation stall.
- Sits between rename and the misprediction recovery logic. Replaces the fixed-size branch state holder.

---
 rtl/branch_checkpoint_table.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/branch_checkpoint_table.sv
// Age-ordered circular table of branch recovery checkpoints. Allocates at rename,
// retires resolved entries in order, and on a misprediction squashes the branch and
// everything younger, then emits a one-cycle restore packet and a configurable stall.
module branch_checkpoint_table #(
    parameter int unsigned CP_NUM         = 4,
    parameter int unsigned AL_SIZE        = 64,
    parameter int unsigned PHYS_REGS      = 64,
    parameter int unsigned ARCH_REGS      = 32,
    parameter int unsigned RECOVER_CYCLES = 1,
    localparam int unsigned CP_IDX = $clog2(CP_NUM),
    localparam int unsigned AL_IDX = $clog2(AL_SIZE),
    localparam int unsigned PR_IDX = $clog2(PHYS_REGS),
    localparam int unsigned MAP_W  = ARCH_REGS * PR_IDX
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              alloc_valid,
    output logic              alloc_ready,
    input  logic [AL_IDX-1:0] alloc_branch_id,
    input  logic              alloc_color,
    input  logic              alloc_ds,
    input  logic [PR_IDX-1:0] alloc_free_head,
    input  logic [MAP_W-1:0]  alloc_map,
    output logic [CP_IDX-1:0] alloc_tag,
    input  logic              res_valid,
    input  logic [CP_IDX-1:0] res_tag,
    input  logic              res_miss,
    output logic              recover_valid,
    output logic [CP_IDX-1:0] recover_tag,
    output logic [PR_IDX-1:0] recover_free_head,
    output logic [MAP_W-1:0]  recover_map,
    output logic [AL_IDX-1:0] recover_youngest,
    output logic              recover_color,
    output logic              busy,
    output logic [CP_IDX:0]   count,
    output logic              full,
    output logic              empty
);

    localparam int unsigned CntW      = CP_IDX + 1;
    localparam int unsigned StallW    = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;
    localparam int unsigned StallInit = (RECOVER_CYCLES > 0) ? RECOVER_CYCLES - 1 : 0;

    typedef enum logic [1:0] {StIdle, StRecover, StStall} state_e;

    state_e              state_q, state_d;
    logic [StallW-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CP_NUM-1:0]   valid_q, valid_d, done_q, done_d;
    logic [CP_IDX-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CntW-1:0]     count_q, count_d;

    // Payload storage
    logic [AL_IDX-1:0]   bid_q   [CP_NUM];
    logic [PR_IDX-1:0]   fhead_q [CP_NUM];
    logic [MAP_W-1:0]    map_q   [CP_NUM];
    logic [CP_NUM-1:0]   color_q, ds_q;

    // Restore packet registers
    logic [CP_IDX-1:0]   rec_tag_q;
    logic [PR_IDX-1:0]   rec_fhead_q;
    logic [MAP_W-1:0]    rec_map_q;
    logic [AL_IDX-1:0]   rec_young_q;
    logic                rec_color_q;

    logic                miss, resolve_ok, retire, miss_retire, alloc_fire;
    logic [CP_IDX-1:0]   miss_age;
    logic [AL_IDX:0]     rec_sum;

    assign full        = (count_q == CntW'(CP_NUM));
    assign empty       = (count_q == '0);
    assign count       = count_q;
    assign alloc_tag   = tail_q;
    assign busy        = (state_q != StIdle);

    assign miss        = res_valid && res_miss && valid_q[res_tag];
    assign resolve_ok  = res_valid && !res_miss && valid_q[res_tag];
    assign retire      = valid_q[head_q] && done_q[head_q];
    assign miss_retire = retire && (head_q != res_tag);
    assign miss_age    = res_tag - head_q;
    assign alloc_ready = (state_q == StIdle) && !full && !(res_valid && res_miss) && !flush;
    assign alloc_fire  = alloc_valid && alloc_ready;

    // Youngest pointer wraps around the active list; the carry out flips the color.
    assign rec_sum = {1'b0, bid_q[res_tag]} + (AL_IDX+1)'(1) + (AL_IDX+1)'(ds_q[res_tag]);

    assign recover_valid     = (state_q == StRecover);
    assign recover_tag       = rec_tag_q;
    assign recover_free_head = rec_fhead_q;
    assign recover_map       = rec_map_q;
    assign recover_youngest  = rec_young_q;
    assign recover_color     = rec_color_q;

    // Next-state for occupancy, pointers and per-entry valid/done flags
    always_comb begin
        valid_d = valid_q;
        done_d  = done_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            valid_d = '0;
            done_d  = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else if (miss) begin
            // Age relative to head: everything at or beyond the mispredicted branch dies.
            for (int i = 0; i < CP_NUM; i++) begin
                if (CP_IDX'(CP_IDX'(i) - head_q) >= miss_age) begin
                    valid_d[i] = 1'b0;
                    done_d[i]  = 1'b0;
                end
            end
            if (miss_retire) begin
                valid_d[head_q] = 1'b0;
                done_d[head_q]  = 1'b0;
                head_d          = head_q + CP_IDX'(1);
            end
            tail_d  = res_tag;
            count_d = {1'b0, miss_age} - CntW'(miss_retire);
        end else begin
            if (resolve_ok) begin
                done_d[res_tag] = 1'b1;
            end
            if (retire) begin
                valid_d[head_q] = 1'b0;
                done_d[head_q]  = 1'b0;
                head_d          = head_q + CP_IDX'(1);
            end
            if (alloc_fire) begin
                valid_d[tail_q] = 1'b1;
                done_d[tail_q]  = 1'b0;
                tail_d          = tail_q + CP_IDX'(1);
            end
            count_d = count_q + CntW'(alloc_fire) - CntW'(retire);
        end
    end

    // Recovery FSM next-state and stall countdown
    always_comb begin
        state_d     = state_q;
        stall_cnt_d = stall_cnt_q;
        if (flush) begin
            state_d     = StIdle;
            stall_cnt_d = '0;
        end else if (miss) begin
            state_d = StRecover;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StIdle;
                end
                StRecover: begin
                    if (RECOVER_CYCLES > 0) begin
                        state_d     = StStall;
                        stall_cnt_d = StallW'(StallInit);
                    end else begin
                        state_d = StIdle;
                    end
                end
                StStall: begin
                    if (stall_cnt_q == '0) begin
                        state_d = StIdle;
                    end else begin
                        stall_cnt_d = stall_cnt_q - StallW'(1);
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // Control state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            stall_cnt_q <= '0;
            valid_q     <= '0;
            done_q      <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            valid_q     <= valid_d;
            done_q      <= done_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
        end
    end

    // Restore packet capture on an accepted mispredict
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rec_tag_q   <= '0;
            rec_fhead_q <= '0;
            rec_map_q   <= '0;
            rec_young_q <= '0;
            rec_color_q <= 1'b0;
        end else if (!flush && miss) begin
            rec_tag_q   <= res_tag;
            rec_fhead_q <= fhead_q[res_tag];
            rec_map_q   <= map_q[res_tag];
            rec_young_q <= rec_sum[AL_IDX-1:0];
            rec_color_q <= color_q[res_tag] ^ rec_sum[AL_IDX];
        end
    end

    // Payload write at tail on an accepted allocation; payload needs no reset
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            bid_q[tail_q]   <= alloc_branch_id;
            fhead_q[tail_q] <= alloc_free_head;
            map_q[tail_q]   <= alloc_map;
            color_q[tail_q] <= alloc_color;
            ds_q[tail_q]    <= alloc_ds;
        end
    end

endmodule
